// File: rtl/haar_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the Haar
// integral-image front end.
package haar_pkg;

    localparam int DEF_PIXEL_W = 8;
    localparam int DEF_INT_W   = 25;
    localparam int DEF_FRAME_W = 320;
    localparam int DEF_FRAME_H = 240;
    localparam int DEF_WIN_W   = 3;
    localparam int DEF_WIN_H   = 3;
    localparam int DEF_COORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int LB_AW = clog2(DEF_FRAME_W);

endpackage

// File: rtl/integral_line_buffer.sv
// Circular delay line: the read word is the one written DEPTH enables ago,
// read before the same slot is overwritten.
module integral_line_buffer
    import haar_pkg::*;
#(
    parameter int WIDTH = DEF_INT_W,
    parameter int DEPTH = DEF_FRAME_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;

    assign dout_o = mem_q[ptr_q];

    // Pointer advance with wrap at the last slot.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/integral_window_buffer.sv
// Streaming integral-image generator with a WIN_W x WIN_H sliding window of
// integral values, frame tracking and frame-error reporting.
module integral_window_buffer
    import haar_pkg::*;
#(
    parameter int PIXEL_W = DEF_PIXEL_W,
    parameter int INT_W   = DEF_INT_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int WIN_H   = DEF_WIN_H,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic                           clk_os,
    input  logic                           reset_os,
    input  logic                           i_valid,
    input  logic                           i_sof,
    input  logic [PIXEL_W-1:0]             i_pixel,
    output logic [WIN_W*WIN_H*INT_W-1:0]   o_window,
    output logic                           o_window_valid,
    output logic [COORD_W-1:0]             o_x,
    output logic [COORD_W-1:0]             o_y,
    output logic                           o_frame_done,
    output logic                           o_frame_err
);

    localparam int XW = clog2(FRAME_W);
    localparam int YW = clog2(FRAME_H);
    localparam int WIN_BITS = WIN_W * WIN_H * INT_W;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
    localparam logic [XW-1:0] X_WIN  = XW'(WIN_W - 1);
    localparam logic [YW-1:0] Y_WIN  = YW'(WIN_H - 1);

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [INT_W-1:0]      rowsum_q, rowsum_d;
    logic                  valid_q, valid_d;
    logic [COORD_W-1:0]    ox_q, ox_d;
    logic [COORD_W-1:0]    oy_q, oy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [WIN_BITS-1:0]   owin_q, owin_d;

    logic                  restart_s;
    logic                  accept_s;
    logic                  last_s;
    logic                  win_ok_s;
    logic [XW-1:0]         px_s;
    logic [YW-1:0]         py_s;
    logic [INT_W-1:0]      rowsum_s;
    logic [INT_W-1:0]      ii_s;
    logic [INT_W-1:0]      lb_out_s [WIN_H-1];
    logic [INT_W-1:0]      row_in_s [WIN_H];
    logic [INT_W-1:0]      win_q [WIN_H][WIN_W];
    logic [INT_W-1:0]      win_d [WIN_H][WIN_W];
    logic [WIN_BITS-1:0]   win_flat_s;

    // A sof always starts a new frame at (0,0); other pixels only count mid-frame.
    assign restart_s = i_valid & i_sof;
    assign accept_s  = i_valid & (i_sof | (state_q == ST_ACTIVE));
    assign px_s      = restart_s ? '0 : x_q;
    assign py_s      = restart_s ? '0 : y_q;
    assign last_s    = (px_s == X_LAST) && (py_s == Y_LAST);
    assign win_ok_s  = accept_s && (px_s >= X_WIN) && (py_s >= Y_WIN);

    // The y==0 mask keeps stale line-buffer contents out of the first row.
    assign rowsum_s = ((px_s == '0) ? '0 : rowsum_q) + INT_W'(i_pixel);
    assign ii_s     = rowsum_s + ((py_s == '0) ? '0 : lb_out_s[0]);

    for (genvar j = 0; j < WIN_H - 1; j++) begin : g_lb
        logic [INT_W-1:0] din_s;
        if (j == 0) begin : g_first
            assign din_s = ii_s;
        end else begin : g_chain
            assign din_s = lb_out_s[j-1];
        end
        integral_line_buffer #(
            .WIDTH (INT_W),
            .DEPTH (FRAME_W)
        ) u_lb (
            .clk_i   (clk_os),
            .reset_i (reset_os),
            .en_i    (accept_s),
            .din_i   (din_s),
            .dout_o  (lb_out_s[j])
        );
    end

    for (genvar r = 0; r < WIN_H; r++) begin : g_row
        if (r == WIN_H - 1) begin : g_cur
            assign row_in_s[r] = ii_s;
        end else begin : g_old
            assign row_in_s[r] = lb_out_s[WIN_H-2-r];
        end
    end

    // Window shift: each row moves one column left and takes its new value at the right.
    always_comb begin
        win_d = win_q;
        if (accept_s) begin
            for (int r = 0; r < WIN_H; r++) begin
                for (int c = 0; c < WIN_W - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][WIN_W-1] = row_in_s[r];
            end
        end else begin
            win_d = win_q;
        end
    end

    // Flatten the next window into the output ordering k = r*WIN_W + c.
    always_comb begin
        win_flat_s = '0;
        for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W; c++) begin
                win_flat_s[(r*WIN_W+c)*INT_W +: INT_W] = win_d[r][c];
            end
        end
    end

    // Next-state for frame position, row accumulator and registered outputs.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rowsum_d = rowsum_q;
        if (accept_s) begin
            rowsum_d = rowsum_s;
            if (last_s) begin
                state_d = ST_DONE;
                x_d     = '0;
                y_d     = '0;
            end else if (px_s == X_LAST) begin
                state_d = ST_ACTIVE;
                x_d     = '0;
                y_d     = py_s + YW'(1);
            end else begin
                state_d = ST_ACTIVE;
                x_d     = px_s + XW'(1);
                y_d     = py_s;
            end
        end else begin
            state_d = state_q;
        end

        valid_d = win_ok_s;
        done_d  = accept_s && last_s;
        ox_d    = win_ok_s ? COORD_W'(px_s) : ox_q;
        oy_d    = win_ok_s ? COORD_W'(py_s) : oy_q;
        owin_d  = win_ok_s ? win_flat_s : owin_q;

        // A sof mid-frame truncates the old frame; data after DONE without sof is stray.
        if (restart_s) begin
            err_d = (state_q == ST_ACTIVE);
        end else if (i_valid && (state_q == ST_DONE)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Frame FSM with its counters and registered outputs.
    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            rowsum_q <= '0;
            valid_q  <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            owin_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rowsum_q <= rowsum_d;
            valid_q  <= valid_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            owin_q   <= owin_d;
        end
    end

    // Window shift registers.
    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            for (int r = 0; r < WIN_H; r++) begin
                for (int c = 0; c < WIN_W; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign o_window       = owin_q;
    assign o_window_valid = valid_q;
    assign o_x            = ox_q;
    assign o_y            = oy_q;
    assign o_frame_done   = done_q;
    assign o_frame_err    = err_q;

endmodule

// File: doc/integral_window_buffer.md
Name: integral_window_buffer

Overview:
- Streaming integral-image generator plus sliding-window buffer for the Haar face-detection pipeline.
- Accepts 8-bit pixels in raster order and computes the integral image on the fly.
- Presents a WIN_W x WIN_H window of integral values to the classifier stages each time a full window is available.
- Successor to the fixed 3x3 integral memory: frame size, window size and integral width are parameters. Adds valid/start-of-frame handshaking, window coordinates and frame-error reporting.

Parameters:
- PIXEL_W, 8: input pixel width.
- INT_W, 25: integral value width. Sums wrap modulo 2^INT_W.
- FRAME_W, 320: pixels per line.
- FRAME_H, 240: lines per frame.
- WIN_W, 3: window width in pixels; range 2..FRAME_W.
- WIN_H, 3: window height in pixels; range 2..FRAME_H.
- COORD_W, 16: width of coordinate outputs.

Ports:
- clk_os, in, 1: system clock.
- reset_os, in, 1: synchronous, active-high reset.
- i_valid, in, 1: pixel qualifier.
- i_sof, in, 1: start of frame; meaningful only with i_valid.
- i_pixel, in, PIXEL_W: pixel value.
- o_window, out, WIN_W*WIN_H*INT_W: flat window. Element k = r*WIN_W+c occupies bits [k*INT_W +: INT_W].
- o_window_valid, out, 1: o_window/o_x/o_y valid this cycle.
- o_x, out, COORD_W: column of the window's bottom-right pixel.
- o_y, out, COORD_W: row of the window's bottom-right pixel.
- o_frame_done, out, 1: one-cycle pulse after the last pixel of the frame.
- o_frame_err, out, 1: sticky; cleared by the next accepted sof.

Behaviour:
- Reset (reset_os high at a clk_os edge):
  - All outputs 0; x/y counters 0; row accumulator 0; FSM in IDLE.
  - Line-buffer RAM contents are not cleared.
- FSM states:
  - IDLE: i_valid&i_sof -> ACTIVE; the pixel is accepted as (0,0). Other pixels are dropped.
  - ACTIVE: each i_valid pixel is accepted. x increments and wraps to 0 at FRAME_W-1, incrementing y. Accepting (FRAME_W-1, FRAME_H-1) -> DONE.
  - DONE: i_valid&i_sof -> ACTIVE, pixel (0,0). i_valid without sof: pixel dropped, o_frame_err set.
- sof during ACTIVE:
  - Counters restart; the pixel is (0,0); o_frame_err set (truncated frame); the new frame proceeds normally.
  - On the same cycle as the last pixel, sof wins: the pixel is (0,0) and no o_frame_done pulse.
- Integral arithmetic:
  - rowsum = (x==0 ? 0 : rowsum) + pixel.
  - ii(x,y) = rowsum + (y==0 ? 0 : ii(x,y-1)).
  - ii(x,y-1) comes from line buffer 0. The y==0 mask makes stale RAM harmless.
  - All adds are INT_W wide and unsigned; overflow wraps without any flag.
- Line buffers:
  - WIN_H-1 chained delay lines, each FRAME_W deep, advancing only on accepted pixels.
  - Buffer j outputs ii(x, y-1-j).
- Window:
  - WIN_H rows; row r = WIN_H-1 is the current ii, row r < WIN_H-1 is line buffer (WIN_H-2-r).
  - Each row feeds a WIN_W shift register advanced on accepted pixels; c = WIN_W-1 is the newest.
  - Element [r][c] = ii(x-WIN_W+1+c, y-WIN_H+1+r).
- Latency:
  - o_window_valid rises exactly 1 cycle after accepting pixel (x,y) with x >= WIN_W-1 and y >= WIN_H-1. It is 0 otherwise, including on idle cycles.
  - o_x/o_y equal that (x,y).
  - o_window holds its value between valid pulses.
- o_frame_done pulses 1 cycle after the final accepted pixel, coincident with the last o_window_valid.
- Gaps in i_valid of any length are allowed mid-line; outputs are unaffected.

Decomposition:
- Package haar_pkg:
  - default widths;
  - FSM state enum (IDLE, ACTIVE, DONE);
  - function clog2 for counter sizing;
  - localparam LB_AW = clog2(FRAME_W).
- Sub-module integral_line_buffer (WIDTH, DEPTH):
  - single-port-read-before-write RAM with a circular pointer, advanced on enable;
  - read data is the value written DEPTH enables earlier.
  - Instantiated WIN_H-1 times in a generate loop.

Test Plan:
- FRAME_W=4, FRAME_H=3, WIN 3x3, all pixels 1, contiguous valid:
  - First o_window_valid 1 cycle after pixel (2,2), with window {1,2,3,2,4,6,3,6,9} and o_x=2, o_y=2.
  - Next valid at (3,2) with window {2,3,4,4,6,8,6,9,12}.
  - o_frame_done coincides with the second valid; exactly 2 valids in total.
- Same frame with random 0-3 idle cycles between pixels -> identical windows and count.
- Ramp pixels (value = x+4y), back-to-back frames with sof each -> second frame windows equal the first; no o_frame_err.
- Pixels before any sof -> no valids, counters stay 0. Then sof at (2,1) of the next frame -> o_frame_err=1, frame restarts, windows correct for the new frame.
- INT_W=8, pixels all 255 -> sums wrap modulo 256, e.g. ii(1,0)=254; no stall or error.
- reset_os asserted mid-frame -> next cycle all outputs 0. Pixels without sof are dropped; a following full frame produces correct windows despite stale RAM.
